apb_reg_slave: RTL

- APB completer (slave): a parameterised bank of read/write registers plus one read-only status word.
- Serves transfers issued by the team's APB master on the UART-to-APB bridge; it is the responder end of the same bus.
- Inserts a programmable number of wait states.
- Flags out-of-range and illegal accesses with pslverr.

---
 rtl/apb_reg_slave.sv | 139 +++++++++++++
 1 files changed

// File: rtl/apb_reg_slave.sv
// APB completer: NREGS read/write registers plus a read-only status word at index NREGS,
// with a fixed number of wait states and pslverr on out-of-range or illegal accesses.
module apb_reg_slave #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDRBITS    = 16,
  parameter int unsigned NREGS       = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   apb_clk,
  input  logic                   reset,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [ADDRBITS-1:0]    paddr,
  input  logic [WIDTH-1:0]       pwdata,
  output logic [WIDTH-1:0]       prdata,
  output logic                   pready,
  output logic                   pslverr,
  input  logic [WIDTH-1:0]       hw_status,
  output logic [NREGS*WIDTH-1:0] regs_flat
);

  localparam int unsigned IdxW = ADDRBITS - 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] prdata_q, prdata_d;
  logic             pready_q, pready_d;
  logic             pslverr_q, pslverr_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  logic [IdxW-1:0]  idx;
  logic             in_regs;
  logic             is_status;
  logic [WIDTH-1:0] reg_rd;
  logic             load_resp;

  // Full word index is compared, so high address bits can never alias onto a register.
  assign idx       = paddr[ADDRBITS-1:2];
  assign in_regs   = idx < IdxW'(NREGS);
  assign is_status = idx == IdxW'(NREGS);

  always_comb begin
    reg_rd = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (idx == IdxW'(i)) reg_rd = regs_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          if (WAIT_CYCLES == 0) begin
            state_d   = StResp;
            load_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      StWait: begin
        if (!psel) begin
          state_d = StIdle;
        end else if (penable) begin
          if (cnt_q == 4'd1) begin
            state_d   = StResp;
            load_resp = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Response outputs are zero everywhere except the single cycle spent in StResp.
  always_comb begin
    pready_d  = load_resp;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (load_resp) begin
      if (pwrite) begin
        pslverr_d = !in_regs;
      end else if (in_regs) begin
        prdata_d = reg_rd;
      end else if (is_status) begin
        prdata_d = hw_status;
      end else begin
        pslverr_d = 1'b1;
      end
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (state_q == StResp && psel && penable && pwrite && in_regs) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (idx == IdxW'(i)) regs_d[i] = pwdata;
      end
    end
  end

  always_ff @(posedge apb_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
  end

endmodule
